// File: rtl/spi_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// spi_tx_arbiter_pkg: shared widths and FSM encoding for the SPI TX arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_tx_arbiter_pkg;

    localparam int WORD_W = 16;
    localparam int ID_W   = 3;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GUARD_WAIT = 2'd1,
        WAIT_BUSY  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_tx_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, searching from ptr upward.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import spi_tx_arbiter_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic found;
    int   target;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        target    = 0;
        for (int k = 0; k < N_CH; k++) begin
            target = int'(ptr) + k;
            if (target >= N_CH) begin
                target = target - N_CH;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (!found && (c == target) && req[c]) begin
                    grant[c]  = 1'b1;
                    grant_idx = ID_W'(c);
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// spi_tx_arbiter: shares one SPI output channel among N_CH word sources.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_tx_arbiter
    import spi_tx_arbiter_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int GUARD     = 4,
    parameter int TIMEOUT   = 65535,
    parameter int SYNC_BUSY = 1
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic [WORD_W*N_CH-1:0]   req_data,
    input  logic [N_CH-1:0]          req_valid,
    output logic [N_CH-1:0]          req_ready,
    input  logic [N_CH-1:0]          ch_en,
    output logic [WORD_W-1:0]        data,
    output logic                     ena,
    input  logic                     busy,
    output logic [ID_W-1:0]          grant_id,
    output logic                     err
);

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [CNT_W-1:0]    cnt;
    logic                busy_s;
    logic [N_CH-1:0]     eligible;
    logic [N_CH-1:0]     grant;
    logic [ID_W-1:0]     grant_idx;
    logic [WORD_W-1:0]   sel_word;
    logic                grant_now;

    generate
        if (SYNC_BUSY != 0) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge sys_clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[0], busy};
                end
            end
            assign busy_s = sync_q[1];
        end else begin : g_raw
            assign busy_s = busy;
        end
    endgenerate

    assign eligible = req_valid & ch_en;

    rr_arbiter #(
        .N_CH(N_CH)
    ) u_rr (
        .req       (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_word = req_data[WORD_W*i +: WORD_W];
            end
        end
    end

    assign grant_now = (state == IDLE) && !busy_s && (|eligible);
    // Gated by rst so the handshake is dead the instant reset asserts.
    assign req_ready = (grant_now && !rst) ? grant : '0;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            data     <= '0;
            ena      <= 1'b0;
            grant_id <= '0;
            err      <= 1'b0;
        end else begin
            ena <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        data     <= sel_word;
                        grant_id <= grant_idx;
                        ena      <= 1'b1;
                        ptr      <= (grant_idx == ID_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
                        cnt      <= '0;
                        state    <= GUARD_WAIT;
                    end
                end
                GUARD_WAIT: begin
                    if (cnt == CNT_W'(GUARD - 1)) begin
                        cnt   <= '0;
                        state <= WAIT_BUSY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (!busy_s) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Stalled serializer: drop the word rather than retry.
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
